// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and single-slave access sequencer with region/IO decode.
// Latency: grant at T, s_req at T+1, response at T+2+W (error access responds at T+1).
// Backpressure: one transaction outstanding; requests are held off (no gnt) until IDLE.
module mem_bus_arbiter #(
  parameter int unsigned WAIT_IMEM   = 1,
  parameter int unsigned WAIT_DMEM   = 2,
  parameter int unsigned WAIT_PERIPH = 1,
  parameter int unsigned WAIT_IO     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_req,
  output logic [15:0] s_addr,
  output logic        s_we,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_be,
  output logic [1:0]  s_region,
  output logic [2:0]  s_io,
  input  logic [31:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        any_req, pick, last;
  logic        take;
  logic [15:0] sel_addr, cap_addr;
  logic        sel_we, cap_we, owner;
  logic [31:0] cap_wdata, rdata_q, resp_data;
  logic [3:0]  cap_be, cnt, wait_w;
  logic [1:0]  sel_region, region_q;
  logic [2:0]  sel_io, io_q;
  logic        sel_err, err_q, resp;

  function automatic logic [1:0] region_of(input logic [15:0] a);
    case (a[15:12])
      4'h0, 4'h1: region_of = 2'd1;
      4'h2, 4'h3: region_of = 2'd2;
      4'h4:       region_of = 2'd3;
      default:    region_of = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] io_of(input logic [15:0] a);
    case (a[15:4])
      12'h781: io_of = 3'd1;
      12'h780: io_of = 3'd2;
      12'h703: io_of = 3'd3;
      12'h702: io_of = 3'd4;
      12'h701: io_of = 3'd5;
      12'h700: io_of = 3'd6;
      default: io_of = 3'd0;
    endcase
  endfunction

  // last = 1 means m1 won the previous grant, so m0 wins the next tie.
  assign any_req    = m0_req | m1_req;
  assign pick       = m1_req & (~m0_req | ~last);
  assign sel_addr   = pick ? m1_addr : m0_addr;
  assign sel_we     = pick ? m1_we : m0_we;
  assign sel_region = region_of(sel_addr);
  assign sel_io     = io_of(sel_addr);
  assign sel_err    = ((sel_region == 2'd0) && (sel_io == 3'd0)) || (sel_we && (sel_region == 2'd1));

  // Wait-state count for the captured access.
  always_comb begin
    wait_w = 4'd0;
    case (region_q)
      2'd1:    wait_w = 4'(WAIT_IMEM);
      2'd2:    wait_w = 4'(WAIT_DMEM);
      2'd3:    wait_w = 4'(WAIT_PERIPH);
      default: wait_w = (io_q != 3'd0) ? 4'(WAIT_IO) : 4'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; error accesses skip straight to the response.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          take      = 1'b1;
          state_nxt = sel_err ? RESP : ACCESS;
        end
      end
      ACCESS:  state_nxt = (wait_w != 4'd0) ? WAIT : RESP;
      WAIT:    state_nxt = (cnt == 4'd1) ? RESP : WAIT;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture on grant, count wait states, sample read data on the last access cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
      cap_be    <= '0;
      region_q  <= '0;
      io_q      <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      rdata_q   <= '0;
    end else begin
      if (take) begin
        last      <= pick;
        owner     <= pick;
        cap_addr  <= sel_addr;
        cap_we    <= sel_we;
        cap_wdata <= pick ? m1_wdata : m0_wdata;
        cap_be    <= pick ? m1_be : m0_be;
        region_q  <= sel_region;
        io_q      <= sel_io;
        err_q     <= sel_err;
      end
      if (state == ACCESS) begin
        cnt <= wait_w;
        if (wait_w == 4'd0) rdata_q <= s_rdata;
      end
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) rdata_q <= s_rdata;
      end
    end
  end

  // Strobes are suppressed while reset is asserted so an in-flight access is dropped.
  assign m0_gnt    = take & ~pick & ~rst;
  assign m1_gnt    = take & pick & ~rst;
  assign s_req     = (state == ACCESS) & ~rst;
  assign s_addr    = cap_addr;
  assign s_we      = cap_we & s_req;
  assign s_wdata   = cap_wdata;
  assign s_be      = s_req ? cap_be : 4'd0;
  assign s_region  = region_q;
  assign s_io      = io_q;
  assign resp      = (state == RESP) & ~rst;
  assign resp_data = (cap_we | err_q) ? 32'd0 : rdata_q;
  assign m0_rvalid = resp & ~owner;
  assign m1_rvalid = resp & owner;
  assign m0_rdata  = m0_rvalid ? resp_data : 32'd0;
  assign m1_rdata  = m1_rvalid ? resp_data : 32'd0;
  assign m0_err    = m0_rvalid & err_q;
  assign m1_err    = m1_rvalid & err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: timestamp-based transaction model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
// A second instance with WAIT_DMEM=15 covers the long-wait case.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0, s_rdata = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, s_req, s_we;
  logic [31:0] m0_rdata, m1_rdata, s_wdata;
  logic [15:0] s_addr;
  logic [3:0]  s_be;
  logic [1:0]  s_region;
  logic [2:0]  s_io;
  logic        d_m0_gnt, d_m0_rvalid, d_m0_err, d_m1_gnt, d_m1_rvalid, d_m1_err, d_s_req, d_s_we;
  logic [31:0] d_m0_rdata, d_m1_rdata, d_s_wdata;
  logic [15:0] d_s_addr;
  logic [3:0]  d_s_be;
  logic [1:0]  d_s_region;
  logic [2:0]  d_s_io;

  int n_checks = 0, n_err = 0, cyc = 0;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_be(s_be),
    .s_region(s_region), .s_io(s_io), .s_rdata(s_rdata));

  mem_bus_arbiter #(.WAIT_DMEM(15)) dut15 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(d_m0_gnt), .m0_rvalid(d_m0_rvalid), .m0_rdata(d_m0_rdata), .m0_err(d_m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(d_m1_gnt), .m1_rvalid(d_m1_rvalid), .m1_rdata(d_m1_rdata), .m1_err(d_m1_err),
    .s_req(d_s_req), .s_addr(d_s_addr), .s_we(d_s_we), .s_wdata(d_s_wdata), .s_be(d_s_be),
    .s_region(d_s_region), .s_io(d_s_io), .s_rdata(s_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- model: memory map and per-transaction timestamps ----------------
  function automatic int m_region(input logic [15:0] a);
    if (a < 16'h2000) return 1;
    if (a < 16'h4000) return 2;
    if (a < 16'h5000) return 3;
    return 0;
  endfunction

  function automatic int m_io(input logic [15:0] a);
    case (a >> 4)
      16'h0781: return 1;
      16'h0780: return 2;
      16'h0703: return 3;
      16'h0702: return 4;
      16'h0701: return 5;
      16'h0700: return 6;
      default:  return 0;
    endcase
  endfunction

  int          idle_at = 0, sreq_at = -1, resp_at = -1, data_at = -1, last_m = 1;
  int          t_owner = 0, t_reg = 0, t_io = 0, t_w = 0, win = 0;
  logic        t_we = 0, t_err = 0;
  logic [15:0] t_addr = 0;
  logic [31:0] t_wd = 0, t_rd = 0;
  logic [3:0]  t_be = 0;

  // Compare process: predict this cycle's outputs from the request history, then compare.
  always @(negedge clk) begin
    logic eg0, eg1, esr, erv0, erv1;
    logic [31:0] erd;
    eg0 = 0; eg1 = 0; esr = 0; erv0 = 0; erv1 = 0; erd = 0;
    if (rst) begin
      idle_at = cyc + 1; sreq_at = -1; resp_at = -1; data_at = -1; last_m = 1;
    end else begin
      if (cyc >= idle_at && (m0_req || m1_req)) begin
        win     = (m0_req && m1_req) ? (last_m == 1 ? 0 : 1) : (m0_req ? 0 : 1);
        t_owner = win;
        t_addr  = win ? m1_addr : m0_addr;
        t_we    = win ? m1_we : m0_we;
        t_wd    = win ? m1_wdata : m0_wdata;
        t_be    = win ? m1_be : m0_be;
        t_reg   = m_region(t_addr);
        t_io    = m_io(t_addr);
        t_w     = (t_reg == 1) ? 1 : (t_reg == 2) ? 2 : (t_reg == 3) ? 1 : 0;
        t_err   = (t_reg == 0 && t_io == 0) || (t_we && t_reg == 1);
        if (t_err) begin
          sreq_at = -1; data_at = -1; resp_at = cyc + 1; idle_at = cyc + 2;
        end else begin
          sreq_at = cyc + 1; data_at = cyc + 1 + t_w; resp_at = cyc + 2 + t_w; idle_at = cyc + 3 + t_w;
        end
        last_m = win;
        if (win == 0) eg0 = 1; else eg1 = 1;
      end
      if (cyc == data_at) t_rd = s_rdata;
      esr = (cyc == sreq_at);
      if (cyc == resp_at) begin
        if (t_owner == 0) erv0 = 1; else erv1 = 1;
        erd = (t_we || t_err) ? 32'd0 : t_rd;
      end
    end
    check("m0_gnt", m0_gnt, eg0);
    check("m1_gnt", m1_gnt, eg1);
    check("s_req", s_req, esr);
    check("s_we", s_we, esr ? t_we : 1'b0);
    check("s_be", s_be, esr ? t_be : 4'd0);
    check("m0_rvalid", m0_rvalid, erv0);
    check("m1_rvalid", m1_rvalid, erv1);
    if (erv0) begin check("m0_rdata", m0_rdata, erd); check("m0_err", m0_err, t_err); end
    if (erv1) begin check("m1_rdata", m1_rdata, erd); check("m1_err", m1_err, t_err); end
    if (!rst && sreq_at >= 0 && cyc >= sreq_at && cyc <= resp_at) begin
      check("s_addr", s_addr, t_addr);
      check("s_wdata", s_wdata, t_wd);
      check("s_region", s_region, t_reg);
      check("s_io", s_io, t_io);
    end
  end

  // ---------------- monitor: records DUT events for the literal checks ----------------
  int          gnt_q[$];
  int          rv_cyc[2] = '{-1, -1}, rv_cnt[2] = '{0, 0};
  logic [31:0] rv_dat[2];
  logic        rv_err[2];
  int          sreq_cnt = 0, sreq_cyc = -1;
  logic [1:0]  sreq_reg;
  logic [2:0]  sreq_io;
  logic        sreq_we;
  logic [3:0]  sreq_be;
  logic [31:0] sreq_wd;
  int          d_gnt_cyc = -1, d_rv_cyc = -1, d_rv_cnt = 0, d_sreq_cnt = 0;
  logic [31:0] d_rv_dat;

  always @(negedge clk) begin
    if (m0_gnt) gnt_q.push_back(0);
    if (m1_gnt) gnt_q.push_back(1);
    if (s_req) begin
      sreq_cnt++; sreq_cyc = cyc; sreq_reg = s_region; sreq_io = s_io;
      sreq_we = s_we; sreq_be = s_be; sreq_wd = s_wdata;
    end
    if (m0_rvalid) begin rv_cnt[0]++; rv_cyc[0] = cyc; rv_dat[0] = m0_rdata; rv_err[0] = m0_err; end
    if (m1_rvalid) begin rv_cnt[1]++; rv_cyc[1] = cyc; rv_dat[1] = m1_rdata; rv_err[1] = m1_err; end
    if (d_m0_gnt) d_gnt_cyc = cyc;
    if (d_s_req) d_sreq_cnt++;
    if (d_m0_rvalid) begin d_rv_cnt++; d_rv_cyc = cyc; d_rv_dat = d_m0_rdata; end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Raise a request, hold it until granted, return the grant cycle.
  task automatic issue(input int m, input logic [15:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] b, output int gc);
    bit got;
    got = 0; gc = -1;
    if (m == 0) begin m0_req = 1; m0_addr = a; m0_we = w; m0_wdata = d; m0_be = b; end
    else        begin m1_req = 1; m1_addr = a; m1_we = w; m1_wdata = d; m1_be = b; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_gnt) || (m == 1 && m1_gnt)) begin got = 1; gc = cyc; end
      @(posedge clk); #1;
    end
    if (m == 0) m0_req = 0; else m1_req = 0;
    if (!got) check("gnt_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gc, n, n15, r15, snap;
    int exp_seq[4];
    exp_seq = '{0, 1, 0, 1};
    tick(3); rst = 0; tick(1);

    // Reset values
    @(negedge clk);
    check("rst_s_req", s_req, 1'b0);
    check("rst_s_region", s_region, 2'd0);
    check("rst_s_io", s_io, 3'd0);
    check("rst_s_addr", s_addr, 16'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rvalid", m1_rvalid, 1'b0);
    tick(1);

    // m1 read of DMEM, 2 wait states
    s_rdata = 32'hDEADBEEF;
    issue(1, 16'h2004, 0, 32'd0, 4'hF, gc);
    tick(6);
    check("dmem_sreq_lat", 32'(sreq_cyc - gc), 32'd1);
    check("dmem_region", sreq_reg, 2'd2);
    check("dmem_rv_lat", 32'(rv_cyc[1] - gc), 32'd4);
    check("dmem_rdata", rv_dat[1], 32'hDEADBEEF);
    check("dmem_err", rv_err[1], 1'b0);

    // Continuous contention: grants alternate starting with m0
    s_rdata = 32'h12345678;
    gnt_q.delete();
    m0_addr = 0; m0_we = 0; m0_be = 4'hF; m1_addr = 0; m1_we = 0; m1_be = 4'hF;
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (gnt_q.size() >= 4) break;
    end
    m0_req = 0; m1_req = 0;
    check("rr_grant_count", 32'(gnt_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < gnt_q.size()) check("rr_order", 32'(gnt_q[i]), 32'(exp_seq[i]));
    tick(6);

    // m1 IO write, no wait states
    issue(1, 16'h7810, 1, 32'hCAFEF00D, 4'b0110, gc);
    tick(4);
    check("io_sreq_lat", 32'(sreq_cyc - gc), 32'd1);
    check("io_code", sreq_io, 3'd1);
    check("io_we", sreq_we, 1'b1);
    check("io_be", sreq_be, 4'b0110);
    check("io_wdata", sreq_wd, 32'hCAFEF00D);
    check("io_rv_lat", 32'(rv_cyc[1] - gc), 32'd2);
    check("io_rdata", rv_dat[1], 32'd0);
    check("io_err", rv_err[1], 1'b0);

    // Unmapped read and read-only write: error, no strobe
    n = sreq_cnt;
    issue(1, 16'h5000, 0, 32'd0, 4'hF, gc);
    tick(3);
    check("unmap_rv_lat", 32'(rv_cyc[1] - gc), 32'd1);
    check("unmap_err", rv_err[1], 1'b1);
    check("unmap_rdata", rv_dat[1], 32'd0);
    issue(1, 16'h0100, 1, 32'h55AA55AA, 4'hF, gc);
    tick(3);
    check("ro_rv_lat", 32'(rv_cyc[1] - gc), 32'd1);
    check("ro_err", rv_err[1], 1'b1);
    check("ro_rdata", rv_dat[1], 32'd0);
    check("err_no_sreq", 32'(sreq_cnt - n), 32'd0);

    // WAIT_DMEM=15 instance: rvalid at T+17, single strobe, single response
    rst = 1; tick(1); rst = 0; tick(1);
    s_rdata = 32'hA5A50001;
    n15 = d_sreq_cnt; r15 = d_rv_cnt;
    issue(0, 16'h3FFC, 0, 32'd0, 4'hF, gc);
    tick(20);
    check("w15_gnt", 32'(d_gnt_cyc), 32'(gc));
    check("w15_sreq_count", 32'(d_sreq_cnt - n15), 32'd1);
    check("w15_rv_lat", 32'(d_rv_cyc - gc), 32'd17);
    check("w15_rv_count", 32'(d_rv_cnt - r15), 32'd1);
    check("w15_rdata", d_rv_dat, 32'hA5A50001);

    // Reset during WAIT drops the access; pointer returns to favour m0
    issue(0, 16'h3FFC, 0, 32'd0, 4'hF, gc);
    snap = rv_cnt[0];
    tick(1);
    rst = 1; tick(1); rst = 0; tick(3);
    check("rst_no_rvalid", 32'(rv_cnt[0] - snap), 32'd0);
    gnt_q.delete();
    m0_addr = 16'h0010; m0_we = 0; m1_addr = 16'h0020; m1_we = 0;
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (gnt_q.size() >= 1) break;
    end
    m0_req = 0; m1_req = 0;
    check("post_rst_one_gnt", 32'(gnt_q.size()), 32'd1);
    if (gnt_q.size() >= 1) check("post_rst_winner", 32'(gnt_q[0]), 32'd0);
    tick(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, single-slave memory bus arbiter and access sequencer for the processor's memory-mapped address space. It accepts requests from the fetch port (m0) and the load/store port (m1), grants one at a time with round-robin fairness, and decodes the 16-bit address into region/IO select codes per the system memory map. It drives a single downstream strobe, inserts per-region wait states, and returns a one-cycle response to the owning master. It sits between the core's fetch/LSU logic and the instruction memory, data memory, peripheral region and IO registers.

## Interface
Parameters:
- WAIT_IMEM, 1, wait cycles for region 1 (0x0000–0x1FFF); legal range 0–15
- WAIT_DMEM, 2, wait cycles for region 2 (0x2000–0x3FFF); 0–15
- WAIT_PERIPH, 1, wait cycles for region 3 (0x4000–0x4FFF); 0–15
- WAIT_IO, 0, wait cycles for IO registers; 0–15

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- mN_req  in  1  request (N = 0, 1); held until mN_gnt
- mN_addr  in  16  byte address
- mN_we  in  1  1 = write
- mN_wdata  in  32  write data
- mN_be  in  4  byte enables
- mN_gnt  out  1  request accepted (combinational, IDLE only)
- mN_rvalid  out  1  one-cycle response pulse
- mN_rdata  out  32  read data, valid with mN_rvalid
- mN_err  out  1  error flag, valid with mN_rvalid
- s_req  out  1  one-cycle downstream access strobe
- s_addr  out  16  captured address
- s_we, s_wdata, s_be  out  1/32/4  captured write controls
- s_region  out  2  decoded region code
- s_io  out  3  decoded IO code
- s_rdata  in  32  slave read data

## Operation
- Decode, from captured address: region = 1 for addr[15:12] in {0,1}; 2 for {2,3}; 3 for 4; else 0. IO code from addr[15:4]: 0x781→1, 0x780→2, 0x703→3, 0x702→4, 0x701→5, 0x700→6, else 0.
- Wait count W is selected from region (1/2/3 → WAIT_IMEM/WAIT_DMEM/WAIT_PERIPH), else WAIT_IO when io ≠ 0.
- Error access: region = 0 and io = 0 (unmapped), or write to region 1 (read-only). There is no downstream strobe for an error access.
- FSM states: IDLE, ACCESS, WAIT, RESP.
  - IDLE: if any req, grant one master (gnt high this cycle) and capture addr/we/wdata/be/owner. Next state is RESP for an error access, else ACCESS.
  - ACCESS: s_req = 1 and load counter with W. Next state is WAIT if W > 0, else sample s_rdata and go to RESP.
  - WAIT: decrement counter; on the cycle the counter is 1, sample s_rdata. Then go to RESP.
  - RESP: rvalid = 1 to owner only. rdata = sampled data for a successful read, 0 for writes and errors. err = 1 for an error access. Next state is IDLE.
- Arbitration: single requester wins. When both request, the master not granted last wins. The pointer updates on each grant and resets to favour m0.
- s_addr/s_we/s_wdata/s_be/s_region/s_io hold their captured values from ACCESS through RESP. s_we/s_be are forced to 0 when s_req = 0.
- Only one transaction is outstanding. A master re-requesting during its own transaction is held until IDLE.

## Timing
- Reset values: state IDLE, all gnt/rvalid/err/s_req = 0, rdata = 0, captured registers = 0, s_region = s_io = 0, RR pointer favours m0.
- Grant at cycle T, s_req at T+1, rvalid at T+2+W.
- Error access: grant at T, rvalid+err at T+1.
- Earliest next grant is the cycle after RESP (T+3+W, or T+2 for an error access).
- Simultaneous requests in IDLE: exactly one gnt.
- Reset asserted in any state: next cycle is IDLE. The transaction in flight is dropped with no rvalid, and s_req drops.
- Counter is 4-bit. W = 0 must not underflow; WAIT is skipped.

## Test plan
- Reset, then m1 read of 0x2004, WAIT_DMEM=2, s_rdata=0xDEADBEEF: gnt at T, s_req at T+1 with s_region=2, m1_rvalid at T+4 with rdata=0xDEADBEEF and err=0.
- m0 and m1 request continuously, both reading 0x0000: grants alternate m0, m1, m0, m1. No master gets two consecutive grants.
- m1 write to 0x7810, WAIT_IO=0: s_req at T+1 with s_io=1, s_we=1, s_be/s_wdata matching the request; rvalid at T+2 with rdata=0 and err=0.
- m1 read of 0x5000 (unmapped) and m1 write of 0x0100 (read-only): no s_req; rvalid at T+1 with err=1 and rdata=0.
- m0 read of 0x3FFC with WAIT_DMEM=15: exactly one s_req, rvalid at T+17, counter does not wrap.
- rst asserted during WAIT: next cycle IDLE, no rvalid; a subsequent simultaneous request is granted to m0.
